bc_msg_broadcast_arbiter: RTL and testbench
===========================================

// Module: bc_msg_broadcast_arbiter
// PURPOSE
// - Collects broadcast messages (bc_msg_out) from CORE_COUNT RISC-V block wrappers and selects one per cycle with a round-robin arbiter.
// - Re-broadcasts the selected message to every core's bc_msg_in on one registered, fan-out valid-only bus.
// - Sits between the per-core pipe-register boundary and the shared broadcast memory region (BC_REGION_SIZE) logic.
// PARAMETERS
// - CORE_COUNT     16    number of cores arbitrated
// - CORE_ID_WIDTH  4     $clog2(CORE_COUNT); width of source-core field
// - BC_REGION_SIZE 8192  bytes in broadcast region; sets address bits in message
// - MSG_WIDTH      32+4+$clog2(BC_REGION_SIZE)-2  {addr, strb[3:0], data[31:0]} = 47 by default
// PORTS
// - clk                  in   1                      clock
// - rst                  in   1                      synchronous active-high reset
// - s_bc_msg             in   CORE_COUNT*MSG_WIDTH   per-core message, core i at [i*MSG_WIDTH +: MSG_WIDTH]
// - s_bc_msg_valid       in   CORE_COUNT             per-core valid
// - s_bc_msg_ready       out  CORE_COUNT             per-core ready (one-hot or zero)
// - core_msg_mask        in   CORE_COUNT             1 = core allowed to broadcast; 0 = core blocked
// - m_bc_msg             out  MSG_WIDTH              broadcast message to all cores
// - m_bc_msg_src         out  CORE_ID_WIDTH          index of originating core
// - m_bc_msg_valid       out  1                      broadcast valid; no ready, receivers always accept
// - stat_rd_addr         in   CORE_ID_WIDTH          statistics counter select
// - stat_rd_data         out  32                     statistics counter value
// BEHAVIOUR
// - Reset: s_bc_msg_ready=0, m_bc_msg_valid=0, m_bc_msg=0, m_bc_msg_src=0, stat_rd_data=0. rr_ptr=CORE_COUNT-1, so core 0 has first priority.
// - Eligible core i: s_bc_msg_valid[i] & core_msg_mask[i].
// - Grant: first eligible index searched circularly from rr_ptr+1 (mod CORE_COUNT), rr_ptr itself last. Grant is combinational, at most one.
// - s_bc_msg_ready = grant one-hot, forced 0 while rst. A transfer occurs on valid&ready in the same cycle.
// - Cycle after a transfer: m_bc_msg_valid=1, m_bc_msg=granted data, m_bc_msg_src=granted index, rr_ptr=granted index.
// - Latency is exactly 1 cycle; throughput is 1 message/cycle sustained.
// - No eligible core: m_bc_msg_valid=0 next cycle; m_bc_msg/m_bc_msg_src hold their last values; rr_ptr unchanged.
// - Wrap: after rr_ptr=CORE_COUNT-1 the search starts at 0. All cores continuously valid -> grants 0,1,..,N-1,0,...
// - Masked core: never granted, its ready stays 0, and its message is held upstream (no drop). Mask changes take effect the same cycle.
// - The output bus has no backpressure. Receivers (bc_msg_in pipe regs) have m_ready tied 1, so nothing is buffered here.
// - Reset mid-operation: a pending output valid is cleared next edge and the message is lost. Upstream senders must retry after core_rst.
// CONFIGURATION
// - BC_MSG_STATS_EN defined:
//   - one 32-bit wrapping counter per core, incremented on each granted transfer, cleared on rst.
//   - stat_rd_data = counter[stat_rd_addr], registered (1-cycle read latency).
// - BC_MSG_STATS_EN undefined: no counters are instantiated and stat_rd_data is constant 0. stat_rd_addr is unused.
// STRUCTURE
// - Shared header bc_msg_defs.vh holds MSG field offsets (DATA_LSB=0, STRB_LSB=32, ADDR_LSB=36), the MSG_WIDTH formula and the CORE_ID_WIDTH derivation.
// - Sub-module rr_arbiter (PORTS, request vector in, one-hot grant + encoded index out, rr_ptr update on an accept strobe) does the grant logic.
// - The top holds the data mux, output register and optional stats.
// TESTING
// - After reset, cores 0,3 valid with msgs 0xA/0xB -> cycle 1 out 0xA src 0, cycle 2 out 0xB src 3, then valid=0.
// - All 16 cores continuously valid -> src sequence 0..15,0 with m_bc_msg_valid high every cycle. Each ready is high exactly once per 16 cycles.
// - core_msg_mask=0xFFFE, core 0 valid only -> s_bc_msg_ready[0] stays 0 for 20 cycles. Clearing the mask -> msg emitted next cycle.
// - Single core 5 valid for 3 back-to-back msgs -> 3 consecutive outputs src=5, with no bubble.
// - rst asserted on the cycle after a grant -> m_bc_msg_valid=0 next edge. After release, core 0 wins ahead of core 15 when both are valid.
// - BC_MSG_STATS_EN: 7 grants to core 2, stat_rd_addr=2 -> stat_rd_data=7 one cycle later. Without the macro, reads return 0.

Source files
------------

// File: rtl/bc_msg_broadcast_arbiter_pkg.sv
// Shared definitions for the broadcast message arbiter: message field
// offsets, default sizing and the message-width derivation.
package bc_msg_broadcast_arbiter_pkg;

  localparam int unsigned DEF_CORE_COUNT     = 16;
  localparam int unsigned DEF_CORE_ID_WIDTH  = $clog2(DEF_CORE_COUNT);
  localparam int unsigned DEF_BC_REGION_SIZE = 8192;

  // Message layout {addr, strb[3:0], data[31:0]}
  localparam int unsigned DATA_LSB   = 0;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STRB_LSB   = 32;
  localparam int unsigned STRB_W     = 4;
  localparam int unsigned ADDR_LSB   = 36;
  localparam int unsigned STAT_WIDTH = 32;

  // Word address into the broadcast region plus strobes and data
  function automatic int unsigned msg_width(input int unsigned region_size);
    return DATA_W + STRB_W + $clog2(region_size) - 2;
  endfunction

  localparam int unsigned DEF_MSG_WIDTH = msg_width(DEF_BC_REGION_SIZE);
  localparam int unsigned DEF_ADDR_W    = DEF_MSG_WIDTH - ADDR_LSB;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [STRB_W-1:0]     strb;
    logic [DATA_W-1:0]     data;
  } bc_msg_t;

endpackage

// File: rtl/bc_msg_broadcast_arbiter_rr_arbiter.sv
// Round-robin arbiter. Grants the first requester found circularly after
// rr_ptr (rr_ptr itself last); rr_ptr moves to the granted index on accept.
// Ports:
//   clk, rst    clock, synchronous active-high reset (rr_ptr -> N-1)
//   req         request vector
//   accept      strobe: the current grant was taken
//   grant       one-hot grant (combinational, zero when no request)
//   grant_idx   encoded grant index
//   grant_any   any grant this cycle
module bc_msg_broadcast_arbiter_rr_arbiter #(
  parameter int unsigned N   = 16,
  parameter int unsigned IDW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           accept,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           grant_any
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cand;

  // Pointer to the most recently granted requester
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= IDW'(N - 1);
    end else if (accept) begin
      rr_ptr <= grant_idx;
    end
  end

  // Circular priority search starting one past rr_ptr
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = IDW'((32'(rr_ptr) + off) % N);
      if (!grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bc_msg_broadcast_arbiter.sv
// Broadcast message arbiter: picks one eligible core message per cycle
// (round robin) and re-broadcasts it, registered, to all cores.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_bc_msg        per-core messages, core i at [i*MSG_WIDTH +: MSG_WIDTH]
//   s_bc_msg_valid  per-core valid
//   s_bc_msg_ready  per-core ready (one-hot or zero, zero during rst)
//   core_msg_mask   1 = core may broadcast
//   m_bc_msg        broadcast message (holds last value when idle)
//   m_bc_msg_src    originating core index
//   m_bc_msg_valid  broadcast valid, no backpressure
//   stat_rd_addr    statistics counter select
//   stat_rd_data    statistics counter value (1-cycle read latency)
// Build option: BC_MSG_STATS_EN adds per-core grant counters; without it
// stat_rd_data is constant 0.
module bc_msg_broadcast_arbiter
  import bc_msg_broadcast_arbiter_pkg::*;
#(
  parameter int unsigned CORE_COUNT     = DEF_CORE_COUNT,
  parameter int unsigned CORE_ID_WIDTH  = $clog2(CORE_COUNT),
  parameter int unsigned BC_REGION_SIZE = DEF_BC_REGION_SIZE,
  parameter int unsigned MSG_WIDTH      = msg_width(BC_REGION_SIZE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_bc_msg,
  input  logic [CORE_COUNT-1:0]           s_bc_msg_valid,
  output logic [CORE_COUNT-1:0]           s_bc_msg_ready,
  input  logic [CORE_COUNT-1:0]           core_msg_mask,
  output logic [MSG_WIDTH-1:0]            m_bc_msg,
  output logic [CORE_ID_WIDTH-1:0]        m_bc_msg_src,
  output logic                            m_bc_msg_valid,
  input  logic [CORE_ID_WIDTH-1:0]        stat_rd_addr,
  output logic [STAT_WIDTH-1:0]           stat_rd_data
);

  logic [CORE_COUNT-1:0]    eligible;
  logic [CORE_COUNT-1:0]    grant;
  logic [CORE_ID_WIDTH-1:0] grant_idx;
  logic                     grant_any;
  logic [MSG_WIDTH-1:0]     sel_msg;

  assign eligible = s_bc_msg_valid & core_msg_mask;

  bc_msg_broadcast_arbiter_rr_arbiter #(
    .N   (CORE_COUNT),
    .IDW (CORE_ID_WIDTH)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (eligible),
    .accept    (grant_any),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Ready is the grant itself, so a grant is always a transfer
  assign s_bc_msg_ready = rst ? '0 : grant;

  // One-hot data mux
  always_comb begin
    sel_msg = '0;
    for (int unsigned i = 0; i < CORE_COUNT; i++) begin
      if (grant[i]) begin
        sel_msg = sel_msg | s_bc_msg[i*MSG_WIDTH +: MSG_WIDTH];
      end
    end
  end

  // Output register; payload holds when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      m_bc_msg_valid <= 1'b0;
      m_bc_msg       <= '0;
      m_bc_msg_src   <= '0;
    end else begin
      m_bc_msg_valid <= grant_any;
      if (grant_any) begin
        m_bc_msg     <= sel_msg;
        m_bc_msg_src <= grant_idx;
      end
    end
  end

`ifdef BC_MSG_STATS_EN
  logic [STAT_WIDTH-1:0] stat_cnt [CORE_COUNT];

  // Per-core wrapping grant counters with registered readback
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CORE_COUNT; i++) begin
        stat_cnt[i] <= '0;
      end
      stat_rd_data <= '0;
    end else begin
      if (grant_any) begin
        stat_cnt[grant_idx] <= stat_cnt[grant_idx] + STAT_WIDTH'(1);
      end
      stat_rd_data <= stat_cnt[stat_rd_addr];
    end
  end
`else
  logic unused_stat_rd_addr;

  assign unused_stat_rd_addr = ^stat_rd_addr;
  assign stat_rd_data        = '0;
`endif

endmodule

// File: tb/tb_bc_msg_broadcast_arbiter.sv
// Testbench for bc_msg_broadcast_arbiter: directed scenarios with a
// reference model compared at every falling edge, plus literal checks.
module tb_bc_msg_broadcast_arbiter;
  import bc_msg_broadcast_arbiter_pkg::*;

  localparam int unsigned N   = 16;
  localparam int unsigned IDW = 4;
  localparam int unsigned MW  = 47;
`ifdef BC_MSG_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [N*MW-1:0]   s_bc_msg;
  logic [N-1:0]      s_bc_msg_valid;
  logic [N-1:0]      s_bc_msg_ready;
  logic [N-1:0]      core_msg_mask;
  logic [MW-1:0]     m_bc_msg;
  logic [IDW-1:0]    m_bc_msg_src;
  logic              m_bc_msg_valid;
  logic [IDW-1:0]    stat_rd_addr;
  logic [31:0]       stat_rd_data;

  bc_msg_broadcast_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .s_bc_msg       (s_bc_msg),
    .s_bc_msg_valid (s_bc_msg_valid),
    .s_bc_msg_ready (s_bc_msg_ready),
    .core_msg_mask  (core_msg_mask),
    .m_bc_msg       (m_bc_msg),
    .m_bc_msg_src   (m_bc_msg_src),
    .m_bc_msg_valid (m_bc_msg_valid),
    .stat_rd_addr   (stat_rd_addr),
    .stat_rd_data   (stat_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Sender-side message queues, one per core
  logic [MW-1:0] q [N][$];
  int            acc_cnt [N];

  // Reference model state
  bit            armed = 1'b0;
  bit            mod_valid;
  logic [MW-1:0] mod_msg;
  int            mod_src;
  int            mod_rr;
  logic [31:0]   mod_cnt [N];
  logic [31:0]   mod_stat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner = eligible core closest after rr (rr itself is farthest)
  function automatic int model_winner();
    int best  = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (s_bc_msg_valid[i] && core_msg_mask[i]) begin
        int d = (i + N - mod_rr - 1) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      s_bc_msg_valid[i]       = (q[i].size() > 0);
      s_bc_msg[i*MW +: MW]    = (q[i].size() > 0) ? q[i][0] : '0;
    end
  endtask

  // One clock: apply inputs, check/advance model at negedge, pop accepted
  task automatic step();
    int            w;
    logic [N-1:0]  exp_ready;
    logic [N-1:0]  accepted;
    drive_inputs();
    @(negedge clk);
    w = model_winner();
    exp_ready = '0;
    if (!rst && w >= 0) exp_ready[w] = 1'b1;
    if (armed) begin
      chk("ready", 64'(s_bc_msg_ready), 64'(exp_ready));
      chk("out_valid", 64'(m_bc_msg_valid), 64'(mod_valid));
      chk("out_msg", 64'(m_bc_msg), 64'(mod_msg));
      chk("out_src", 64'(m_bc_msg_src), 64'(mod_src));
      chk("stat_data", 64'(stat_rd_data), 64'(mod_stat));
    end
    accepted = s_bc_msg_ready & s_bc_msg_valid;
    if (rst) begin
      mod_valid = 1'b0;
      mod_msg   = '0;
      mod_src   = 0;
      mod_rr    = N - 1;
      mod_stat  = '0;
      for (int i = 0; i < N; i++) mod_cnt[i] = '0;
      armed = 1'b1;
    end else begin
      mod_stat = STATS_EN ? mod_cnt[stat_rd_addr] : 32'd0;
      if (w >= 0) begin
        mod_valid  = 1'b1;
        mod_msg    = q[w][0];
        mod_src    = w;
        mod_rr     = w;
        mod_cnt[w] = mod_cnt[w] + 32'd1;
      end else begin
        mod_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (accepted[i] && q[i].size() > 0) begin
        void'(q[i].pop_front());
        acc_cnt[i]++;
      end
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      acc_cnt[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    core_msg_mask = '1;
    stat_rd_addr  = '0;
    clear_queues();
    step();
    step();
    rst = 1'b0;
  endtask

  int good;

  initial begin
    rst            = 1'b1;
    core_msg_mask  = '1;
    stat_rd_addr   = '0;
    s_bc_msg       = '0;
    s_bc_msg_valid = '0;
    do_reset();
    chk("reset_valid", 64'(m_bc_msg_valid), 64'd0);
    chk("reset_msg", 64'(m_bc_msg), 64'd0);
    chk("reset_ready", 64'(s_bc_msg_ready), 64'd0);

    // Cores 0 and 3 with one message each
    q[0].push_back(47'hA);
    q[3].push_back(47'hB);
    step();
    chk("t1_c1_valid", 64'(m_bc_msg_valid), 64'd1);
    chk("t1_c1_msg", 64'(m_bc_msg), 64'hA);
    chk("t1_c1_src", 64'(m_bc_msg_src), 64'd0);
    step();
    chk("t1_c2_msg", 64'(m_bc_msg), 64'hB);
    chk("t1_c2_src", 64'(m_bc_msg_src), 64'd3);
    step();
    chk("t1_c3_valid", 64'(m_bc_msg_valid), 64'd0);
    chk("t1_c3_hold", 64'(m_bc_msg), 64'hB);

    // All cores continuously valid
    do_reset();
    for (int i = 0; i < N; i++) begin
      q[i].push_back(47'(i * 16));
      q[i].push_back(47'(i * 16 + 1));
    end
    for (int k = 0; k < N; k++) begin
      step();
      chk("t2_valid", 64'(m_bc_msg_valid), 64'd1);
      chk("t2_src", 64'(m_bc_msg_src), 64'(k));
      chk("t2_msg", 64'(m_bc_msg), 64'(k * 16));
    end
    good = 0;
    for (int i = 0; i < N; i++) if (acc_cnt[i] == 1) good++;
    chk("t2_once_each", 64'(good), 64'(N));
    step();
    chk("t2_wrap_src", 64'(m_bc_msg_src), 64'd0);
    chk("t2_wrap_msg", 64'(m_bc_msg), 64'd1);

    // Masked core is held, then released
    do_reset();
    core_msg_mask = 16'hFFFE;
    q[0].push_back(47'h123);
    repeat (20) step();
    chk("t3_masked_acc", 64'(acc_cnt[0]), 64'd0);
    chk("t3_masked_valid", 64'(m_bc_msg_valid), 64'd0);
    core_msg_mask = '1;
    step();
    chk("t3_unmask_valid", 64'(m_bc_msg_valid), 64'd1);
    chk("t3_unmask_src", 64'(m_bc_msg_src), 64'd0);
    chk("t3_unmask_msg", 64'(m_bc_msg), 64'h123);

    // Back-to-back from a single core
    do_reset();
    q[5].push_back(47'h51);
    q[5].push_back(47'h52);
    q[5].push_back(47'h53);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_valid", 64'(m_bc_msg_valid), 64'd1);
      chk("t4_src", 64'(m_bc_msg_src), 64'd5);
      chk("t4_msg", 64'(m_bc_msg), 64'(8'h51 + k));
    end
    step();
    chk("t4_idle", 64'(m_bc_msg_valid), 64'd0);

    // Reset right after a grant
    do_reset();
    q[7].push_back(47'h77);
    step();
    chk("t5_grant_valid", 64'(m_bc_msg_valid), 64'd1);
    rst = 1'b1;
    q[1].push_back(47'h11);
    step();
    chk("t5_rst_valid", 64'(m_bc_msg_valid), 64'd0);
    chk("t5_rst_acc", 64'(acc_cnt[1]), 64'd0);
    rst = 1'b0;
    clear_queues();
    q[0].push_back(47'h100);
    q[15].push_back(47'h1F);
    step();
    chk("t5_first_src", 64'(m_bc_msg_src), 64'd0);
    step();
    chk("t5_second_src", 64'(m_bc_msg_src), 64'd15);

    // Statistics readback
    do_reset();
    for (int k = 0; k < 7; k++) q[2].push_back(47'(32'h200 + k));
    repeat (7) step();
    stat_rd_addr = 4'd2;
    step();
    chk("t6_stat_core2", 64'(stat_rd_data), STATS_EN ? 64'd7 : 64'd0);
    stat_rd_addr = 4'd3;
    step();
    chk("t6_stat_core3", 64'(stat_rd_data), 64'd0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
